rc4_prga_decryptor: RTL and testbench

//  RC4 PRGA keystream generator and decryptor, parametrised by message length.
//  - Runs on an S-box RAM that the KSA stage has already initialised.
//  - Performs the i/j swaps itself: no precomputed j table needed.
//  - Reads ciphertext from a ROM, XORs it with the keystream, writes plaintext to a RAM.
//  - Flags whether the plaintext is all lowercase/space, for the key-search controller.

---
 rtl/rc4_prga_decryptor.sv | 165 ++++++++++++++++
 tb/tb_rc4_prga_decryptor.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_prga_decryptor.sv
// RC4 PRGA stage: swaps S in place, XORs keystream with ciphertext, writes plaintext.
// Optional build macro RC4_EARLY_ABORT_EN stops the run at the first non-text byte.
module rc4_prga_decryptor #(
  parameter int MSG_LEN = 32,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  localparam int MSG_AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_we,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [MSG_AW-1:0] msg_addr,
  input  logic [DATA_W-1:0] msg_rdata,
  output logic [MSG_AW-1:0] out_addr,
  output logic [DATA_W-1:0] out_wdata,
  output logic              out_we
);

  typedef enum logic [3:0] {
    IDLE, RD_SI, WT_SI, RD_SJ, WT_SJ, WR_SI, WR_SJ, RD_F, WT_F, WR_OUT, DONE
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d, j_q, j_d;
  logic [MSG_AW-1:0] k_q, k_d;
  logic [DATA_W-1:0] si_q, si_d, sj_q, sj_d, f_q, f_d, c_q, c_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] plain;
  logic              byte_ok, last_byte;

  function automatic logic is_text(input logic [DATA_W-1:0] b);
    return ((b >= DATA_W'(8'h61)) && (b <= DATA_W'(8'h7A))) || (b == DATA_W'(8'h20));
  endfunction

  assign plain     = f_q ^ c_q;
  assign byte_ok   = is_text(plain);
  assign last_byte = (k_q == MSG_AW'(MSG_LEN - 1));
  assign valid     = valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      f_q     <= '0;
      c_q     <= '0;
      valid_q <= 1'b1;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      f_q     <= f_d;
      c_q     <= c_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    si_d      = si_q;
    sj_d      = sj_q;
    f_d       = f_q;
    c_d       = c_q;
    valid_d   = valid_q;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_we      = 1'b0;
    msg_addr  = '0;
    out_addr  = '0;
    out_wdata = '0;
    out_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          i_d     = ADDR_W'(1);
          j_d     = '0;
          k_d     = '0;
          valid_d = 1'b1;
          state_d = RD_SI;
        end
      end
      RD_SI: begin
        s_addr  = i_q;
        state_d = WT_SI;
      end
      WT_SI: begin
        si_d    = s_rdata;
        j_d     = j_q + ADDR_W'(s_rdata);
        state_d = RD_SJ;
      end
      RD_SJ: begin
        s_addr  = j_q;
        state_d = WT_SJ;
      end
      WT_SJ: begin
        sj_d    = s_rdata;
        state_d = WR_SI;
      end
      // When i==j both writes carry the same byte, so the swap degenerates cleanly.
      WR_SI: begin
        s_addr  = i_q;
        s_wdata = sj_q;
        s_we    = 1'b1;
        state_d = WR_SJ;
      end
      WR_SJ: begin
        s_addr  = j_q;
        s_wdata = si_q;
        s_we    = 1'b1;
        state_d = RD_F;
      end
      RD_F: begin
        s_addr   = ADDR_W'(si_q + sj_q);
        msg_addr = k_q;
        state_d  = WT_F;
      end
      WT_F: begin
        f_d     = s_rdata;
        c_d     = msg_rdata;
        state_d = WR_OUT;
      end
      WR_OUT: begin
        out_addr  = k_q;
        out_wdata = plain;
        out_we    = 1'b1;
        if (!byte_ok) valid_d = 1'b0;
`ifdef RC4_EARLY_ABORT_EN
        if (last_byte || !byte_ok) begin
`else
        if (last_byte) begin
`endif
          state_d = DONE;
        end else begin
          i_d     = i_q + ADDR_W'(1);
          k_d     = k_q + MSG_AW'(1);
          state_d = RD_SI;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc4_prga_decryptor.sv
// Directed bench for rc4_prga_decryptor: short 4-byte instance plus a 300-byte instance
// that exercises the i wrap; memories are modelled beside the DUTs.
module tb_rc4_prga_decryptor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  // ---------------- 4-byte instance ----------------
  logic       start_a, busy_a, done_a, valid_a, s_we_a, out_we_a;
  logic [7:0] s_addr_a, s_wdata_a, s_rdata_a, msg_rdata_a, out_wdata_a;
  logic [1:0] msg_addr_a, out_addr_a;
  logic [7:0] s_mem_a [256];
  logic [7:0] cipher_a [4];
  logic [7:0] out_mem_a [4];
  int         out_cnt_a;
  logic       ksa_a = 1'b0, clr_a = 1'b0;

  rc4_prga_decryptor #(.MSG_LEN(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a), .valid(valid_a),
    .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_we(s_we_a), .s_rdata(s_rdata_a),
    .msg_addr(msg_addr_a), .msg_rdata(msg_rdata_a),
    .out_addr(out_addr_a), .out_wdata(out_wdata_a), .out_we(out_we_a)
  );

  always @(posedge clk) begin
    if (ksa_a) for (int x = 0; x < 256; x++) s_mem_a[x] <= 8'(x);
    else if (s_we_a) s_mem_a[s_addr_a] <= s_wdata_a;
    s_rdata_a   <= s_mem_a[s_addr_a];
    msg_rdata_a <= cipher_a[msg_addr_a];
    if (clr_a) out_cnt_a <= 0;
    else if (out_we_a) begin
      out_mem_a[out_addr_a] <= out_wdata_a;
      out_cnt_a <= out_cnt_a + 1;
    end
  end

  // ---------------- 300-byte instance ----------------
  logic       start_b, busy_b, done_b, valid_b, s_we_b, out_we_b;
  logic [7:0] s_addr_b, s_wdata_b, s_rdata_b, msg_rdata_b, out_wdata_b;
  logic [8:0] msg_addr_b, out_addr_b;
  logic [7:0] s_mem_b [256];
  logic [7:0] cipher_b [300];
  logic [7:0] out_mem_b [300];
  int         out_cnt_b;
  logic       ksa_b = 1'b0, clr_b = 1'b0;

  rc4_prga_decryptor #(.MSG_LEN(300)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b), .valid(valid_b),
    .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_we(s_we_b), .s_rdata(s_rdata_b),
    .msg_addr(msg_addr_b), .msg_rdata(msg_rdata_b),
    .out_addr(out_addr_b), .out_wdata(out_wdata_b), .out_we(out_we_b)
  );

  always @(posedge clk) begin
    if (ksa_b) for (int x = 0; x < 256; x++) s_mem_b[x] <= 8'(x);
    else if (s_we_b) s_mem_b[s_addr_b] <= s_wdata_b;
    s_rdata_b   <= s_mem_b[s_addr_b];
    msg_rdata_b <= cipher_b[msg_addr_b];
    if (clr_b) out_cnt_b <= 0;
    else if (out_we_b) begin
      out_mem_b[out_addr_b] <= out_wdata_b;
      out_cnt_b <= out_cnt_b + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic prep_a();
    ksa_a = 1'b1; clr_a = 1'b1;
    @(negedge clk);
    ksa_a = 1'b0; clr_a = 1'b0;
  endtask

  // Edges counted from the start-sampling edge until done is seen.
  task automatic run_a(output int cyc);
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("run_a_done_seen", {31'd0, done_a}, 32'd1);
  endtask

  task automatic set_cipher_a(input logic [31:0] w);
    for (int n = 0; n < 4; n++) cipher_a[n] = w[31-8*n -: 8];
  endtask

  int         cyc, ndone, d1, d2, busy_d1p1, busy_d1p2;
  logic       xbad;
  logic [7:0] a254, a255;
  logic [7:0] ms [256];
  logic [7:0] mi, mj, mt, mix;
  int         bad_bytes;

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    set_cipher_a(32'h0);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy",  {31'd0, busy_a},  32'd0);
    check("rst_done",  {31'd0, done_a},  32'd0);
    check("rst_valid", {31'd0, valid_a}, 32'd1);
    check("rst_s_we",  {31'd0, s_we_a},  32'd0);
    check("rst_out_we",{31'd0, out_we_a},32'd0);
    check("rst_s_addr",{24'd0, s_addr_a},32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Test 1 / 3: identity S, zero cipher
    prep_a();
    run_a(cyc);
`ifdef RC4_EARLY_ABORT_EN
    check("t3_latency", cyc, 32'd9);
    check("t3_out_cnt", out_cnt_a, 32'd1);
    check("t3_out0",    {24'd0, out_mem_a[0]}, 32'h02);
    check("t3_valid",   {31'd0, valid_a}, 32'd0);
`else
    check("t1_latency", cyc, 32'd36);
    check("t1_out_cnt", out_cnt_a, 32'd4);
    check("t1_out0", {24'd0, out_mem_a[0]}, 32'h02);
    check("t1_out1", {24'd0, out_mem_a[1]}, 32'h05);
    check("t1_out2", {24'd0, out_mem_a[2]}, 32'h07);
    check("t1_out3", {24'd0, out_mem_a[3]}, 32'h0D);
    check("t1_valid", {31'd0, valid_a}, 32'd0);
    check("t1_S2", {24'd0, s_mem_a[2]}, 32'h03);
    check("t1_S3", {24'd0, s_mem_a[3]}, 32'h05);
    check("t1_S4", {24'd0, s_mem_a[4]}, 32'h09);
    check("t1_S5", {24'd0, s_mem_a[5]}, 32'h02);
    check("t1_S9", {24'd0, s_mem_a[9]}, 32'h04);
`endif
    @(negedge clk);
    check("t1_done_pulse", {31'd0, done_a}, 32'd0);
    check("t1_idle_busy",  {31'd0, busy_a}, 32'd0);
    check("t1_valid_hold", {31'd0, valid_a}, 32'd0);

    // Test 2: "abc "
    set_cipher_a(32'h6367642D);
    prep_a();
    run_a(cyc);
    check("t2_latency", cyc, 32'd36);
    check("t2_out0", {24'd0, out_mem_a[0]}, 32'h61);
    check("t2_out1", {24'd0, out_mem_a[1]}, 32'h62);
    check("t2_out2", {24'd0, out_mem_a[2]}, 32'h63);
    check("t2_out3", {24'd0, out_mem_a[3]}, 32'h20);
    check("t2_valid", {31'd0, valid_a}, 32'd1);
    ndone = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    check("t2_single_done", ndone, 32'd0);

    // Test 4: reset in WR_SI of byte 2 (i=3)
    prep_a();
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    for (int n = 0; n < 22; n++) @(negedge clk);
    check("t4_in_wr_si_we",   {31'd0, s_we_a},  32'd1);
    check("t4_in_wr_si_addr", {24'd0, s_addr_a}, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check("t4_busy",  {31'd0, busy_a},  32'd0);
    check("t4_done",  {31'd0, done_a},  32'd0);
    check("t4_valid", {31'd0, valid_a}, 32'd1);
    check("t4_s_we",  {31'd0, s_we_a},  32'd0);
    check("t4_out_we",{31'd0, out_we_a},32'd0);
    reset = 1'b0;
    @(negedge clk);
`ifdef RC4_EARLY_ABORT_EN
    prep_a();
    run_a(cyc);
    check("t4_rerun_out0", {24'd0, out_mem_a[0]}, 32'h61);
    check("t4_rerun_out3", {24'd0, out_mem_a[3]}, 32'h20);
`else
    set_cipher_a(32'h0);
    prep_a();
    run_a(cyc);
    check("t4_rerun_out0", {24'd0, out_mem_a[0]}, 32'h02);
    check("t4_rerun_out1", {24'd0, out_mem_a[1]}, 32'h05);
    check("t4_rerun_out2", {24'd0, out_mem_a[2]}, 32'h07);
    check("t4_rerun_out3", {24'd0, out_mem_a[3]}, 32'h0D);
`endif
    @(negedge clk);

    // Test 5a: start pulsed mid-run is ignored
    set_cipher_a(32'h6367642D);
    prep_a();
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    cyc = 0; ndone = 0; d1 = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) start_a = 1'b1;
      if (cyc == 11) start_a = 1'b0;
      if (done_a) begin
        ndone++;
        if (d1 == 0) d1 = cyc;
      end
    end
    check("t5_ignored_ndone", ndone, 32'd1);
    check("t5_ignored_lat",   d1, 32'd36);

    // Test 5b: start held high re-arms right after done
    prep_a();
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 0; d1 = 0; d2 = 0; busy_d1p1 = -1; busy_d1p2 = -1;
    while (d2 == 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (d1 != 0 && cyc == d1 + 1) busy_d1p1 = int'(busy_a);
      if (d1 != 0 && cyc == d1 + 2) busy_d1p2 = int'(busy_a);
      if (done_a) begin
        if (d1 == 0) d1 = cyc;
        else d2 = cyc;
      end
    end
    start_a = 1'b0;
    check("t5_held_first", d1, 32'd36);
    check("t5_held_idle_gap", busy_d1p1, 32'd0);
    check("t5_held_rearm", busy_d1p2, 32'd1);
`ifndef RC4_EARLY_ABORT_EN
    check("t5_held_second", d2 - d1, 32'd38);
`endif
    for (int n = 0; n < 400 && busy_a; n++) @(negedge clk);
    check("t5_held_settled", {31'd0, busy_a}, 32'd0);

    // Test 6: 300-byte run; plaintext chosen as 'a'+k%26, cipher built from reference keystream
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
    mi = 8'd0; mj = 8'd0;
    for (int k = 0; k < 300; k++) begin
      mi = mi + 8'd1;
      mj = mj + ms[mi];
      mt = ms[mi]; ms[mi] = ms[mj]; ms[mj] = mt;
      mix = ms[mi] + ms[mj];
      cipher_b[k] = ms[mix] ^ (8'h61 + 8'(k % 26));
    end
    ksa_b = 1'b1; clr_b = 1'b1;
    @(negedge clk);
    ksa_b = 1'b0; clr_b = 1'b0;
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    cyc = 0; xbad = 1'b0; a254 = 8'hAA; a255 = 8'hAA;
    while (!done_b && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if ($isunknown({s_addr_b, msg_addr_b, out_addr_b, s_wdata_b, out_wdata_b, s_we_b, out_we_b}))
        xbad = 1'b1;
      if (cyc == 9*254) a254 = s_addr_b;
      if (cyc == 9*255) a255 = s_addr_b;
    end
    check("t6_done_seen", {31'd0, done_b}, 32'd1);
    check("t6_latency", cyc, 32'd2700);
    check("t6_no_x", {31'd0, xbad}, 32'd0);
    check("t6_i_byte254", {24'd0, a254}, 32'hFF);
    check("t6_i_byte255", {24'd0, a255}, 32'h00);
    check("t6_out_cnt", out_cnt_b, 32'd300);
    check("t6_valid", {31'd0, valid_b}, 32'd1);
    bad_bytes = 0;
    for (int k = 0; k < 300; k++)
      if (out_mem_b[k] !== (8'h61 + 8'(k % 26))) bad_bytes++;
    check("t6_all_bytes", bad_bytes, 32'd0);
    check("t6_out255", {24'd0, out_mem_b[255]}, 32'h76);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
